// File: rtl/ac97_sdata_in_deframer.sv
// ac97_sdata_in_deframer
//   Controller-side AC'97 receive deframer. Aligns to the SYNC we drive to the
//   codec, deserialises the 256-bit SDATA_IN frame and publishes the tag,
//   status address/data (slots 1-2) and PCM left/right (slots 3-4) once the
//   whole frame has arrived. Runs entirely in the BIT_CLK domain.
//
//   Valid/ready semantics: there is no back-pressure. FRAME_DONE, STATUS_VALID,
//   PCM_VALID and SYNC_ERR are single-cycle pulses. Field outputs change only on
//   a FRAME_DONE cycle and hold their values until the next publish.
//
// Ports
//   BIT_CLK        in   codec bit clock, rising-edge sampling
//   SYSTEM_RESET_N in   async active-low reset
//   SYNC           in   frame sync as driven to the codec
//   SDATA_IN       in   serial data from the codec, MSB first
//   CODEC_READY    out  tag bit 15 of the last complete frame
//   TAG            out  tag bits 15:3 of the last complete frame
//   STATUS_ADDR    out  slot1 bits 18:12
//   STATUS_DATA    out  slot2 bits 19:4
//   PCM_L / PCM_R  out  slot3 / slot4 [19 -: PCM_WIDTH]
//   FRAME_DONE     out  pulse: complete frame published
//   STATUS_VALID   out  pulse with FRAME_DONE when STATUS_* updated
//   PCM_VALID      out  pulse with FRAME_DONE when PCM_* updated
//   SYNC_ERR       out  pulse: framing error, frame discarded

module ac97_sdata_in_deframer #(
   parameter int PCM_WIDTH      = 16,
   parameter bit CHECK_SYNC_LEN = 1'b1
) (
   input  logic                 BIT_CLK,
   input  logic                 SYSTEM_RESET_N,
   input  logic                 SYNC,
   input  logic                 SDATA_IN,
   output logic                 CODEC_READY,
   output logic [12:0]          TAG,
   output logic [6:0]           STATUS_ADDR,
   output logic [15:0]          STATUS_DATA,
   output logic [PCM_WIDTH-1:0] PCM_L,
   output logic [PCM_WIDTH-1:0] PCM_R,
   output logic                 FRAME_DONE,
   output logic                 STATUS_VALID,
   output logic                 PCM_VALID,
   output logic                 SYNC_ERR
);

   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic        sync_q;
   logic        sync_rise;
   logic        shift_en;
   logic        pub_pend, pub_pend_nxt;
   logic        err_now;
   logic        err_pend;
   // Only the first 96 bits (tag + slots 1..4) are kept; slots 5..12 pass by.
   // After bit 95: [95:80] tag, [79:60] slot1, [59:40] slot2, [39:20] slot3, [19:0] slot4.
   logic [95:0] shreg;
   logic        unused_bits;

   assign sync_rise = SYNC & ~sync_q;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge BIT_CLK or negedge SYSTEM_RESET_N) begin
      if (!SYSTEM_RESET_N) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         pub_pend <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         pub_pend <= pub_pend_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pub_pend_nxt = 1'b0;
      err_now      = 1'b0;
      shift_en     = 1'b0;
      case (state)
         IDLE: begin
            if (sync_rise) begin
               state_nxt = RECV;
               cnt_nxt   = 8'd0;
            end
         end
         RECV: begin
            shift_en = (cnt < 8'd96);
            if (cnt == 8'd255) begin
               // Last bit: publish on the next edge. A rise here is the normal
               // back-to-back case and simply re-arms.
               pub_pend_nxt = 1'b1;
               cnt_nxt      = 8'd0;
               state_nxt    = sync_rise ? RECV : IDLE;
            end else if (sync_rise) begin
               // Early rise: drop this frame, this edge arms the next one.
               err_now = 1'b1;
               cnt_nxt = 8'd0;
            end else if (CHECK_SYNC_LEN && (cnt <= 8'd15) && (SYNC != (cnt != 8'd15))) begin
               // SYNC must be high for k = 0..14 and low at k = 15.
               err_now   = 1'b1;
               cnt_nxt   = 8'd0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge BIT_CLK or negedge SYSTEM_RESET_N) begin
      if (!SYSTEM_RESET_N) begin
         sync_q       <= 1'b0;
         shreg        <= '0;
         err_pend     <= 1'b0;
         CODEC_READY  <= 1'b0;
         TAG          <= '0;
         STATUS_ADDR  <= '0;
         STATUS_DATA  <= '0;
         PCM_L        <= '0;
         PCM_R        <= '0;
         FRAME_DONE   <= 1'b0;
         STATUS_VALID <= 1'b0;
         PCM_VALID    <= 1'b0;
         SYNC_ERR     <= 1'b0;
      end else begin
         sync_q <= SYNC;
         // On a back-to-back publish edge this shift takes bit 0 of the new
         // frame while the publish below still reads the completed frame.
         if (shift_en) shreg <= {shreg[94:0], SDATA_IN};

         // A SYNC violation at k=0 of a back-to-back frame lands on the
         // publish edge; its SYNC_ERR is deferred one cycle so the two pulses
         // never coincide.
         err_pend <= err_now & pub_pend;
         SYNC_ERR <= (err_now & ~pub_pend) | err_pend;

         FRAME_DONE   <= pub_pend;
         STATUS_VALID <= 1'b0;
         PCM_VALID    <= 1'b0;
         if (pub_pend) begin
            CODEC_READY <= shreg[95];
            TAG         <= shreg[95:83];
            if (shreg[94] && shreg[93]) begin
               STATUS_ADDR  <= shreg[78:72];
               STATUS_DATA  <= shreg[59:44];
               STATUS_VALID <= 1'b1;
            end
            if (shreg[92] && shreg[91]) begin
               PCM_L     <= shreg[39 -: PCM_WIDTH];
               PCM_R     <= shreg[19 -: PCM_WIDTH];
               PCM_VALID <= 1'b1;
            end
         end
      end
   end

   // Slot bits that are received but not forwarded are sunk here.
   assign unused_bits = ^shreg;

endmodule

// File: tb/tb_ac97_sdata_in_deframer.sv
module tb_ac97_sdata_in_deframer;

  // ---------------------------------------------------------------- clock / reset
  logic BIT_CLK = 1'b0;
  logic SYSTEM_RESET_N;
  logic SYNC;
  logic SDATA_IN;
  always #5 BIT_CLK = ~BIT_CLK;

  logic [31:0] cyc = 32'd0;
  always @(posedge BIT_CLK) cyc <= cyc + 32'd1;

  // DUT with SYNC length checking (main checked instance)
  logic        CODEC_READY, FRAME_DONE, STATUS_VALID, PCM_VALID, SYNC_ERR;
  logic [12:0] TAG;
  logic [6:0]  STATUS_ADDR;
  logic [15:0] STATUS_DATA, PCM_L, PCM_R;

  ac97_sdata_in_deframer #(.PCM_WIDTH(16), .CHECK_SYNC_LEN(1'b1)) dut (
    .BIT_CLK(BIT_CLK), .SYSTEM_RESET_N(SYSTEM_RESET_N), .SYNC(SYNC), .SDATA_IN(SDATA_IN),
    .CODEC_READY(CODEC_READY), .TAG(TAG), .STATUS_ADDR(STATUS_ADDR), .STATUS_DATA(STATUS_DATA),
    .PCM_L(PCM_L), .PCM_R(PCM_R), .FRAME_DONE(FRAME_DONE), .STATUS_VALID(STATUS_VALID),
    .PCM_VALID(PCM_VALID), .SYNC_ERR(SYNC_ERR)
  );

  // DUT without SYNC length checking, same stimulus
  logic        n_codec_ready, n_frame_done, n_status_valid, n_pcm_valid, n_sync_err;
  logic [12:0] n_tag;
  logic [6:0]  n_status_addr;
  logic [15:0] n_status_data, n_pcm_l, n_pcm_r;

  ac97_sdata_in_deframer #(.PCM_WIDTH(16), .CHECK_SYNC_LEN(1'b0)) dut_nochk (
    .BIT_CLK(BIT_CLK), .SYSTEM_RESET_N(SYSTEM_RESET_N), .SYNC(SYNC), .SDATA_IN(SDATA_IN),
    .CODEC_READY(n_codec_ready), .TAG(n_tag), .STATUS_ADDR(n_status_addr), .STATUS_DATA(n_status_data),
    .PCM_L(n_pcm_l), .PCM_R(n_pcm_r), .FRAME_DONE(n_frame_done), .STATUS_VALID(n_status_valid),
    .PCM_VALID(n_pcm_valid), .SYNC_ERR(n_sync_err)
  );

  // ---------------------------------------------------------------- scoreboard
  typedef struct packed {
    logic        is_err;
    logic [31:0] cyc;
    logic        sv;
    logic        pv;
    logic        cr;
    logic [12:0] tag;
    logic [6:0]  addr;
    logic [15:0] data;
    logic [15:0] pl;
    logic [15:0] pr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done_nochk = 0;
  logic [31:0] arm_cyc = 32'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input logic sv, input logic pv, input logic cr, input logic [12:0] tag,
                              input logic [6:0] addr, input logic [15:0] data,
                              input logic [15:0] pl, input logic [15:0] pr);
    exp_t e;
    e.is_err = 1'b0; e.cyc = 32'd0;
    e.sv = sv; e.pv = pv; e.cr = cr; e.tag = tag;
    e.addr = addr; e.data = data; e.pl = pl; e.pr = pr;
    return e;
  endfunction

  function automatic logic [95:0] pay(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                                      input logic [19:0] s3, input logic [19:0] s4);
    return {tag, s1, s2, s3, s4};
  endfunction

  task automatic push_err(input logic [31:0] at);
    exp_t e;
    e = '0;
    e.is_err = 1'b1;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per output pulse
  always @(negedge BIT_CLK) begin
    exp_t e;
    if (SYSTEM_RESET_N) begin
      if ((STATUS_VALID || PCM_VALID) && !FRAME_DONE)
        chk("valid_without_done", {STATUS_VALID, PCM_VALID, FRAME_DONE}, 3'b000);
      if (FRAME_DONE || SYNC_ERR) begin
        chk("done_err_exclusive", FRAME_DONE & SYNC_ERR, 1'b0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event done=%b err=%b at cyc %0d, required no event", FRAME_DONE, SYNC_ERR, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind_err", SYNC_ERR, e.is_err);
          chk("event_cycle", cyc, e.cyc);
          if (!e.is_err) begin
            chk("valid_flags", {STATUS_VALID, PCM_VALID}, {e.sv, e.pv});
            chk("codec_ready", CODEC_READY, e.cr);
            chk("tag", TAG, e.tag);
            chk("status_addr", STATUS_ADDR, e.addr);
            chk("status_data", STATUS_DATA, e.data);
            chk("pcm_l", PCM_L, e.pl);
            chk("pcm_r", PCM_R, e.pr);
          end
        end
      end
    end
  end

  always @(negedge BIT_CLK) if (n_frame_done) n_done_nochk++;

  // ---------------------------------------------------------------- drivers
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge BIT_CLK);
      SYNC = 1'b0;
      SDATA_IN = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic arm();
    @(negedge BIT_CLK);
    SYNC = 1'b1;
    SDATA_IN = 1'($urandom_range(0, 1));
    arm_cyc = cyc + 32'd1;
  endtask

  // Drives bits k = 0..255 of a frame armed at arm_cyc. sync_hi counts SYNC-high
  // samples including the arm edge. chain_out raises SYNC on the k=255 edge.
  // abort_k >= 0 raises SYNC early at that bit instead (new arm, error expected).
  task automatic send_frame(input logic [95:0] p, input exp_t e, input int sync_hi,
                            input bit chain_out, input int abort_k, input bit expect_pub);
    logic [31:0] this_arm;
    logic [31:0] next_arm;
    this_arm = arm_cyc;
    next_arm = arm_cyc;
    for (int k = 0; k < 256; k++) begin
      @(negedge BIT_CLK);
      if (k == abort_k) begin
        SYNC = 1'b1;
        SDATA_IN = 1'b0;
        arm_cyc = cyc + 32'd1;
        push_err(cyc + 32'd1);
        return;
      end
      SDATA_IN = (k < 96) ? p[95 - k] : 1'($urandom_range(0, 1));
      SYNC = (k <= sync_hi - 2);
      if (k == 255 && chain_out) begin
        SYNC = 1'b1;
        next_arm = cyc + 32'd1;
      end
    end
    if (expect_pub) begin
      e.cyc = this_arm + 32'd257;
      exp_q.push_back(e);
    end
    arm_cyc = next_arm;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    SYNC = 1'b0;
    SDATA_IN = 1'b0;
    SYSTEM_RESET_N = 1'b0;
    repeat (3) @(negedge BIT_CLK);
    chk("reset_outputs", {CODEC_READY, TAG, STATUS_ADDR, STATUS_DATA, PCM_L, PCM_R,
                          FRAME_DONE, STATUS_VALID, PCM_VALID, SYNC_ERR}, 128'd0);
    SYSTEM_RESET_N = 1'b1;
    idle(5);

    // 1: full frame, status + PCM valid
    arm();
    send_frame(pay(16'hF800, 20'h26000, 20'h0F000, 20'h12345, 20'hABCDE),
               mk(1, 1, 1, 13'h1F00, 7'h26, 16'h0F00, 16'h1234, 16'hABCD), 16, 0, -1, 1);
    // 2: PCM only, status held
    arm();
    send_frame(pay(16'h9800, 20'h7F000, 20'h55550, 20'h0BEEF, 20'hFACE1),
               mk(0, 1, 1, 13'h1300, 7'h26, 16'h0F00, 16'h0BEE, 16'hFACE), 16, 0, -1, 1);
    idle(4);

    // 3: early rise at k=100, next frame counted from that rise
    arm();
    send_frame(pay(16'hF800, 20'h11111, 20'h22222, 20'h33333, 20'h44444),
               mk(0, 0, 0, 13'h0, 7'h0, 16'h0, 16'h0, 16'h0), 16, 0, 100, 0);
    send_frame(pay(16'hE000, 20'h15000, 20'hC0DE0, 20'h12121, 20'h34343),
               mk(1, 0, 1, 13'h1C00, 7'h15, 16'hC0DE, 16'h0BEE, 16'hFACE), 16, 0, -1, 1);
    idle(3);

    // 4: three back-to-back frames, SYNC period 256
    arm();
    send_frame(pay(16'h7800, 20'h01000, 20'h00010, 20'h80000, 20'h7FFFF),
               mk(1, 1, 0, 13'h0F00, 7'h01, 16'h0001, 16'h8000, 16'h7FFF), 16, 1, -1, 1);
    send_frame(pay(16'h0000, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF),
               mk(0, 0, 0, 13'h0000, 7'h01, 16'h0001, 16'h8000, 16'h7FFF), 16, 1, -1, 1);
    send_frame(pay(16'hFFFF, 20'hFFFFF, 20'hFFFFF, 20'h5A5A5, 20'hA5A5A),
               mk(1, 1, 1, 13'h1FFF, 7'h7F, 16'hFFFF, 16'h5A5A, 16'hA5A5), 16, 0, -1, 1);

    // 5: reset at k=40 of a frame
    arm();
    for (int k = 0; k < 40; k++) begin
      @(negedge BIT_CLK);
      SYNC = (k <= 14);
      SDATA_IN = 1'($urandom_range(0, 1));
    end
    @(negedge BIT_CLK);
    SYSTEM_RESET_N = 1'b0;
    #1;
    chk("async_reset_outputs", {CODEC_READY, TAG, STATUS_ADDR, STATUS_DATA, PCM_L, PCM_R,
                                FRAME_DONE, STATUS_VALID, PCM_VALID, SYNC_ERR}, 128'd0);
    chk("async_reset_outputs_nochk", {n_codec_ready, n_tag, n_status_addr, n_status_data, n_pcm_l, n_pcm_r,
                                      n_frame_done, n_status_valid, n_pcm_valid, n_sync_err}, 128'd0);
    repeat (2) @(negedge BIT_CLK);
    SYNC = 1'b0;
    @(negedge BIT_CLK);
    SYSTEM_RESET_N = 1'b1;
    idle(300);
    arm();
    send_frame(pay(16'h6000, 20'h33000, 20'h12340, 20'hFFFFF, 20'hFFFFF),
               mk(1, 0, 0, 13'h0C00, 7'h33, 16'h1234, 16'h0000, 16'h0000), 16, 0, -1, 1);
    idle(3);

    // 6: SYNC high only 8 bits -> error at k=7 (checked), normal publish (unchecked)
    arm();
    push_err(arm_cyc + 32'd8);
    send_frame(pay(16'hF800, 20'h11000, 20'h22220, 20'h44444, 20'h33333),
               mk(0, 0, 0, 13'h0, 7'h0, 16'h0, 16'h0, 16'h0), 8, 0, -1, 0);
    repeat (2) @(negedge BIT_CLK);
    chk("nochk_short_sync_publish", {n_frame_done, n_pcm_l, n_pcm_r}, {1'b1, 16'h4444, 16'h3333});
    chk("chk_short_sync_no_publish", {PCM_L, PCM_R}, {16'h0000, 16'h0000});

    // checked instance recovers on the next good frame
    arm();
    send_frame(pay(16'h1800, 20'h00000, 20'h00000, 20'h99990, 20'h11110),
               mk(0, 1, 0, 13'h0300, 7'h33, 16'h1234, 16'h9999, 16'h1111), 16, 0, -1, 1);

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge BIT_CLK);
    idle(4);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("nochk_frame_count", n_done_nochk, 9);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
